// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the immediate-decode stage.
// Pure declarations, no timing.
// No flow control lives here.
package imm_pkg;

  // Widest datapath the stage supports; result records are sized for it.
  localparam int XLEN_MAX = 64;

  // RV32I/RV64I base opcodes (instr[6:0]) that carry an immediate or are legal.
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    I    = 3'd1,
    S    = 3'd2,
    B    = 3'd3,
    U    = 3'd4,
    J    = 3'd5,
    R    = 3'd6
  } imm_fmt_t;

  // One decoded instruction. Wide fields are XLEN_MAX bits; a narrower
  // pipe keeps the upper bits zero and ignores them.
  typedef struct packed {
    logic [XLEN_MAX-1:0] imm;
    imm_fmt_t            fmt;
    logic                illegal;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] target;
  } imm_res_t;

  localparam imm_res_t RES_RESET = '{
    imm:     '0,
    fmt:     NONE,
    illegal: 1'b0,
    pc:      '0,
    target:  '0
  };

  // Opcode to immediate format; anything unrecognised is NONE.
  function automatic imm_fmt_t opc_to_fmt(input logic [6:0] opc);
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM: return I;
      OPC_STORE:            return S;
      OPC_BRANCH:           return B;
      OPC_LUI, OPC_AUIPC:   return U;
      OPC_JAL:              return J;
      OPC_OP:               return R;
      default:              return NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational decode of one instruction word + PC into an imm_res_t.
// Zero latency; pure logic between the input port and the pipe registers.
// No flow control; the enclosing pipe decides when the result is captured.
module imm_extract
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output imm_res_t        res
);

  imm_fmt_t        fmt;
  logic            sx;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_x;
  logic [XLEN-1:0] target_x;

  // Select the format, assemble the 32-bit immediate and widen it to XLEN.
  always_comb begin
    fmt = (instr[1:0] == 2'b11) ? opc_to_fmt(instr[6:0]) : NONE;
    // Fill bit for the short formats; zero when extension is unsigned.
    sx  = SIGN_EXT & instr[31];
    case (fmt)
      I:       imm32 = {{20{sx}}, instr[31:20]};
      S:       imm32 = {{20{sx}}, instr[31:25], instr[11:7]};
      B:       imm32 = {{19{sx}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      U:       imm32 = {instr[31:12], 12'b0};
      J:       imm32 = {{11{sx}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;  // R has no immediate; NONE is illegal
    endcase
    // U already occupies bit 31, so the XLEN widening handles its sign too.
    if (SIGN_EXT) imm_x = XLEN'($signed(imm32));
    else          imm_x = XLEN'(imm32);
    // Wraps modulo 2^XLEN; the carry-out is intentionally dropped.
    target_x = pc + imm_x;
  end

  // Pack into the shared result record.
  always_comb begin
    res         = RES_RESET;
    res.imm     = XLEN_MAX'(imm_x);
    res.fmt     = fmt;
    res.illegal = (fmt == NONE);
    res.pc      = XLEN_MAX'(pc);
    res.target  = XLEN_MAX'(target_x);
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// Immediate-generation stage: decode instr/pc into imm, format, illegal, target.
// 1 cycle from input transfer to out_valid when the output register is free.
// Two-entry main+skid buffer; in_ready is a register (= !skid_valid), no out_ready path.
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_target
);

  imm_res_t dec;
  imm_res_t main_q;
  imm_res_t skid_q;
  logic     main_valid;
  logic     skid_valid;
  logic     in_fire;
  logic     main_open;

  imm_extract #(
    .XLEN     (XLEN),
    .SIGN_EXT (SIGN_EXT)
  ) u_extract (
    .instr (in_instr),
    .pc    (in_pc),
    .res   (dec)
  );

  // The skid slot only fills while main is held, so a free skid slot
  // always means there is room for one more entry.
  assign in_ready  = !skid_valid;
  assign in_fire   = in_valid && in_ready;
  // Main can take a new entry when empty or being drained this cycle.
  assign main_open = !main_valid || out_ready;

  // Occupancy: flush empties both slots; skid refills main before new input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_open) begin
      if (skid_valid) begin
        // in_ready is low here, so no input can be competing for main.
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= in_fire;
      end
    end else if (in_fire) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload: main only changes when it is open, keeping data stable under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= RES_RESET;
      skid_q <= RES_RESET;
    end else if (!flush) begin
      if (main_open) begin
        if (skid_valid)   main_q <= skid_q;
        else if (in_fire) main_q <= dec;
      end else if (in_fire) begin
        skid_q <= dec;
      end
    end
  end

  assign out_valid   = main_valid;
  assign out_imm     = main_q.imm[XLEN-1:0];
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_pc      = main_q.pc[XLEN-1:0];
  assign out_target  = main_q.target[XLEN-1:0];

  // Narrow pipes carry always-zero upper record bits; fold them into a
  // deliberately unused net so they are visibly intentional.
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{main_q.imm[XLEN_MAX-1:XLEN],
                         main_q.pc[XLEN_MAX-1:XLEN],
                         main_q.target[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench for imm_decode_pipe (XLEN=32 main instance, XLEN=64 side instance).
// Checks decode values, 1-cycle latency, skid backpressure, flush and async reset.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_imm_decode_pipe;
  import imm_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] in_instr, in_pc, out_imm, out_pc, out_target;
  imm_fmt_t    out_fmt;

  logic        in_valid64, in_ready64, out_valid64, out_illegal64;
  logic [63:0] in_pc64, out_imm64, out_pc64, out_target64;
  imm_fmt_t    out_fmt64;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  imm_decode_pipe #(.XLEN(32), .SIGN_EXT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
    .out_illegal(out_illegal), .out_pc(out_pc), .out_target(out_target)
  );

  imm_decode_pipe #(.XLEN(64), .SIGN_EXT(1'b1)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_pc(out_pc64), .out_target(out_target64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction until accepted (bounded), then drop in_valid.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    int waited = 0;
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    while (!in_ready && waited < 20) begin tick(); waited++; end
    if (!in_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid64 = 1'b0;
    out_ready = 1'b1; in_instr = 32'h0; in_pc = 32'h0; in_pc64 = 64'h0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%0b want=0", out_valid); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got=%0b want=1", in_ready); end
    vectors++; if (out_imm !== 32'h0) begin miscompares++; $display("FAIL rst_imm got=%h want=0", out_imm); end
    vectors++; if (out_fmt !== NONE) begin miscompares++; $display("FAIL rst_fmt got=%0d want=%0d", out_fmt, NONE); end
    vectors++; if (out_illegal !== 1'b0) begin miscompares++; $display("FAIL rst_illegal got=%0b want=0", out_illegal); end
    vectors++; if (out_pc !== 32'h0 || out_target !== 32'h0) begin miscompares++; $display("FAIL rst_pc_target got=%h/%h want=0/0", out_pc, out_target); end
  endtask

  task automatic test_i_format();
    send(32'hFFF00093, 32'h0);
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_latency out_valid=%0b want=1", out_valid); end
    vectors++; if (out_imm !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL addi_imm got=%h want=ffffffff", out_imm); end
    vectors++; if (out_fmt !== I || out_illegal !== 1'b0) begin miscompares++; $display("FAIL addi_fmt got=%0d/%0b want=%0d/0", out_fmt, out_illegal, I); end
    tick();
  endtask

  task automatic test_b_s_format();
    send(32'hFE000EE3, 32'h100);
    vectors++; if (out_imm !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL beq_imm got=%h want=fffffffc", out_imm); end
    vectors++; if (out_fmt !== B) begin miscompares++; $display("FAIL beq_fmt got=%0d want=%0d", out_fmt, B); end
    vectors++; if (out_target !== 32'hFC || out_pc !== 32'h100) begin miscompares++; $display("FAIL beq_target got=%h pc=%h want=fc pc=100", out_target, out_pc); end
    // sw x2,-8(x1)
    send(32'hFE20AC23, 32'h40);
    vectors++; if (out_imm !== 32'hFFFFFFF8 || out_fmt !== S) begin miscompares++; $display("FAIL sw_imm got=%h/%0d want=fffffff8/%0d", out_imm, out_fmt, S); end
    tick();
  endtask

  task automatic test_xlen64();
    in_valid64 = 1'b1; in_instr = 32'hFE000EE3; in_pc64 = 64'h100;
    tick();
    in_valid64 = 1'b0;
    vectors++; if (out_valid64 !== 1'b1) begin miscompares++; $display("FAIL b64_valid got=%0b want=1", out_valid64); end
    vectors++; if (out_imm64 !== 64'hFFFFFFFFFFFFFFFC) begin miscompares++; $display("FAIL b64_imm got=%h want=fffffffffffffffc", out_imm64); end
    vectors++; if (out_target64 !== 64'hFC || out_fmt64 !== B) begin miscompares++; $display("FAIL b64_target got=%h/%0d want=fc/%0d", out_target64, out_fmt64, B); end
    tick();
  endtask

  task automatic test_u_j_format();
    send(32'h123452B7, 32'h40);
    vectors++; if (out_imm !== 32'h12345000 || out_fmt !== U) begin miscompares++; $display("FAIL lui_imm got=%h/%0d want=12345000/%0d", out_imm, out_fmt, U); end
    vectors++; if (out_target !== 32'h12345040) begin miscompares++; $display("FAIL lui_target got=%h want=12345040", out_target); end
    send(32'h0010006F, 32'h200);
    vectors++; if (out_imm !== 32'h800 || out_fmt !== J) begin miscompares++; $display("FAIL jal_imm got=%h/%0d want=800/%0d", out_imm, out_fmt, J); end
    vectors++; if (out_target !== 32'hA00) begin miscompares++; $display("FAIL jal_target got=%h want=a00", out_target); end
    // jal +8 from the top of the address space wraps to 0x4
    send(32'h0080006F, 32'hFFFFFFFC);
    vectors++; if (out_target !== 32'h4 || out_imm !== 32'h8) begin miscompares++; $display("FAIL wrap_target got=%h imm=%h want=4 imm=8", out_target, out_imm); end
    tick();
  endtask

  task automatic test_illegal_r();
    send(32'h00000000, 32'h10);
    vectors++; if (out_illegal !== 1'b1 || out_fmt !== NONE || out_imm !== 32'h0) begin miscompares++; $display("FAIL zero_word got=%0b/%0d/%h want=1/0/0", out_illegal, out_fmt, out_imm); end
    send(32'hFFF0007F, 32'h14);
    vectors++; if (out_illegal !== 1'b1 || out_fmt !== NONE || out_imm !== 32'h0) begin miscompares++; $display("FAIL opc_7f got=%0b/%0d/%h want=1/0/0", out_illegal, out_fmt, out_imm); end
    // add x3,x1,x2
    send(32'h002081B3, 32'h18);
    vectors++; if (out_illegal !== 1'b0 || out_fmt !== R || out_imm !== 32'h0) begin miscompares++; $display("FAIL add_r got=%0b/%0d/%h want=0/%0d/0", out_illegal, out_fmt, out_imm, R); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [4];
    int k = 0;
    int got = 0;
    int last = -1;
    logic acc;
    pcs = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    for (int c = 0; c < 12; c++) begin
      out_ready = (c >= 3);
      in_valid  = (k < 4);
      in_instr  = 32'hFFF00093;
      in_pc     = pcs[(k < 4) ? k : 3];
      if (c == 2) begin
        vectors++; if (in_ready !== 1'b0 || k != 2) begin miscompares++; $display("FAIL stream_ready_fall in_ready=%0b accepted=%0d want=0/2", in_ready, k); end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (got >= 4) begin
          miscompares++; $display("FAIL stream_extra pc=%h want=no output", out_pc);
        end else if (out_pc !== pcs[got] || out_target !== pcs[got] - 32'h1) begin
          miscompares++; $display("FAIL stream_order idx=%0d pc=%h target=%h want=%h/%h", got, out_pc, out_target, pcs[got], pcs[got] - 32'h1);
        end
        if (last >= 0 && c != last + 1) begin
          vectors++; miscompares++; $display("FAIL stream_gap cycle=%0d want=%0d", c, last + 1);
        end
        last = c;
        got++;
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) k++;
    end
    in_valid = 1'b0;
    vectors++; if (got != 4) begin miscompares++; $display("FAIL stream_count got=%0d want=4", got); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drained out_valid=%0b want=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'hFFF00093, 32'h2000);
    send(32'hFFF00093, 32'h2004);
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pre full in_ready=%0b out_valid=%0b want=0/1", in_ready, out_valid); end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h2008;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_full out_valid=%0b in_ready=%0b want=0/1", out_valid, in_ready); end
    // An input offered during flush on an empty pipe must be discarded.
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h200C;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_discard out_valid=%0b want=0", out_valid); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h123452B7, 32'h3000);
    send(32'h0010006F, 32'h3004);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_flags out_valid=%0b in_ready=%0b want=0/1", out_valid, in_ready); end
    vectors++; if (out_imm !== 32'h0 || out_fmt !== NONE || out_illegal !== 1'b0) begin miscompares++; $display("FAIL arst_data imm=%h fmt=%0d ill=%0b want=0/0/0", out_imm, out_fmt, out_illegal); end
    vectors++; if (out_pc !== 32'h0 || out_target !== 32'h0) begin miscompares++; $display("FAIL arst_pc pc=%h target=%h want=0/0", out_pc, out_target); end
    #2 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h80);
    vectors++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fmt !== I) begin miscompares++; $display("FAIL post_rst v=%0b imm=%h fmt=%0d want=1/ffffffff/%0d", out_valid, out_imm, out_fmt, I); end
    vectors++; if (out_target !== 32'h7F || out_pc !== 32'h80) begin miscompares++; $display("FAIL post_rst_target got=%h pc=%h want=7f/80", out_target, out_pc); end
    tick();
  endtask

  initial begin
    test_reset();
    test_i_format();
    test_b_s_format();
    test_xlen64();
    test_u_j_format();
    test_illegal_r();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/imm_decode_pipe.md
Name: imm_decode_pipe

Overview:
- Pipelined, parametrised immediate-generation stage for the RV32I/RV64I front end.
- Accepts one instruction word plus its PC per valid/ready handshake.
- Returns the sign-extended immediate, a format code, an illegal flag and a PC-relative target after one registered cycle.
- A two-entry skid buffer keeps in_ready registered, so fetch and execute timing stay decoupled.

Parameters:
- XLEN, 32, datapath width; 32 or 64 only. Immediate, PC and target are XLEN bits.
- SIGN_EXT, 1, when 1 all immediates are sign-extended to XLEN; when 0 they are zero-extended (debug/ROM use only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset. Single clock domain; reset asserts asynchronously.
- flush  input  1  synchronous pipeline kill (branch redirect).
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  stage can accept; equals NOT skid_valid.
- in_instr  input  32  instruction word.
- in_pc  input  XLEN  PC of in_instr.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_imm  output  XLEN  decoded immediate.
- out_fmt  output  3  format code, encoded as in the package.
- out_illegal  output  1  unsupported opcode or instr[1:0] != 2'b11.
- out_pc  output  XLEN  PC passed through with the instruction.
- out_target  output  XLEN  out_pc + out_imm, modulo 2^XLEN.

Behaviour:
- Transfers:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
- Opcode to format mapping:
  - 0010011, 0000011, 1100111, 1110011 and 0001111 map to I.
  - 0100011 maps to S; 1100011 maps to B.
  - 0110111 and 0010111 map to U; 1101111 maps to J.
  - 0110011 maps to R, with imm = 0.
  - Anything else, or instr[1:0] != 2'b11, gives fmt NONE, imm = 0, illegal = 1.
- Immediate construction, before extension:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U = {instr[31:12], 12'b0}; the bit-31 sign is extended to XLEN.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Target:
  - Computed in the decode cycle with XLEN-bit wrap-around; no carry-out is kept.
  - Meaningful only for B, J and AUIPC; for other formats it is still computed but is don't-care.
- Latency: exactly 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Output register (main):
  - Loads when it is empty, or when it is being drained this cycle.
  - Otherwise an accepted input goes to the skid register.
- Skid register:
  - Holds at most one entry.
  - Moves into main on the next output transfer.
- in_ready = !skid_valid, driven from a register, with no combinational path from out_ready.
- Ordering is strictly FIFO; no entry is dropped or duplicated under any out_ready pattern.
- Simultaneous input and output transfer with the skid register empty: main reloads with the new entry and out_valid stays 1.
- Simultaneous input and output transfer with the skid register full is impossible, because in_ready = 0.
- flush:
  - Next cycle, out_valid = 0 and skid_valid = 0.
  - An input presented in the flush cycle is discarded.
  - in_ready = 1 the cycle after the flush.
  - flush has priority over all transfers.
- Reset values: out_valid = 0, skid_valid = 0, in_ready = 1, out_imm = 0, out_fmt = NONE, out_illegal = 0, out_pc = 0, out_target = 0.
  - Reset mid-stream drops all entries immediately, asynchronously.
- Output data is held stable while out_valid && !out_ready.

Decomposition:
- Package imm_pkg holds:
  - Opcode localparams: OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP.
  - typedef enum logic [2:0] imm_fmt_t: NONE = 0, I = 1, S = 2, B = 3, U = 4, J = 5, R = 6.
  - Packed struct imm_res_t {imm, fmt, illegal, pc, target}.
- Sub-module imm_extract: purely combinational instr/pc to imm_res_t.
  - Instantiated once; the skid and output registers live in imm_decode_pipe.

Test Plan:
- addi x1,x0,-1 (0xFFF00093), pc 0x0 -> one cycle later out_imm 0xFFFFFFFF, fmt I, illegal 0.
- beq x0,x0,-4 (0xFE000EE3), pc 0x100 -> out_imm 0xFFFFFFFC, fmt B, out_target 0xFC. The same case with XLEN = 64 gives out_imm 0xFFFFFFFFFFFFFFFC.
- lui x5,0x12345 (0x123452B7) -> out_imm 0x12345000, fmt U. jal x0,+2048 (0x0010006F) -> out_imm 0x800, fmt J.
- Stream 4 instructions with out_ready = 0 for 3 cycles:
  - in_ready falls after 2 are accepted.
  - On release, all 4 emerge in order, 1 per cycle, with no loss.
- 0x00000000 and opcode 0x7F -> illegal 1, fmt NONE, imm 0. Target wrap: pc 0xFFFFFFFC with JAL +8 -> out_target 0x4.
- flush while both registers are full -> out_valid 0 and in_ready 1 next cycle.
- rst_n low mid-stream -> all outputs reach reset values asynchronously; the first post-reset instruction decodes correctly.
